// File: rtl/df_ctrl_pkg.sv
// Shared dataflow-control types for the tile pointer generator.
// Holds the TilePointers half of the DMA parameter set (inclusive loop limits plus
// per-level offset steps for each stream), the sequencer state type and the offset bundle.
package df_ctrl_pkg;

  localparam int unsigned TILE_CNT_W  = 12;
  localparam int unsigned TILE_STEP_W = 24;
  localparam int unsigned TILE_ADDR_W = 32;

  typedef struct packed {
    logic [TILE_STEP_W-1:0] x_step;
    logic [TILE_STEP_W-1:0] y_step;
    logic [TILE_STEP_W-1:0] k_step;
  } PsumsSteps;

  typedef struct packed {
    logic [TILE_STEP_W-1:0] x_step;
    logic [TILE_STEP_W-1:0] y_step;
    logic [TILE_STEP_W-1:0] c_step;
  } IfmapsSteps;

  typedef struct packed {
    logic [TILE_STEP_W-1:0] k_step;
    logic [TILE_STEP_W-1:0] c_step;
  } WeightsSteps;

  // Limits are inclusive last indices: lim=0 means one tile in that dimension.
  typedef struct packed {
    logic [TILE_CNT_W-1:0] x_lim;
    logic [TILE_CNT_W-1:0] y_lim;
    logic [TILE_CNT_W-1:0] c_lim;
    logic [TILE_CNT_W-1:0] k_lim;
    PsumsSteps             psums;
    IfmapsSteps            ifmaps;
    WeightsSteps           weights;
  } TilePointers;

  typedef enum logic [1:0] {
    TPG_IDLE = 2'd0,
    TPG_RUN  = 2'd1,
    TPG_DONE = 2'd2
  } TilePtrState;

  typedef struct packed {
    logic [TILE_ADDR_W-1:0] psums;
    logic [TILE_ADDR_W-1:0] ifmaps;
    logic [TILE_ADDR_W-1:0] weights;
    logic                   first_c;
    logic                   last_c;
    logic                   last_tile;
  } TileOffsets;

endpackage

// File: rtl/df_tile_ptr_gen_loop.sv
// One level of the tile loop nest.
// Ports: i_clk/i_rstn clock and async active-low reset; i_clr synchronous zero;
// i_inc advance request; i_lim inclusive last index; o_idx current index;
// o_wrap index sits at its limit; o_carry advance that wraps (feeds the next outer level).
module df_loop_level
  import df_ctrl_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_clr,
  input  logic                  i_inc,
  input  logic [TILE_CNT_W-1:0] i_lim,
  output logic [TILE_CNT_W-1:0] o_idx,
  output logic                  o_wrap,
  output logic                  o_carry
);

  logic [TILE_CNT_W-1:0] r_idx;

  assign o_idx   = r_idx;
  assign o_wrap  = (r_idx == i_lim);
  assign o_carry = i_inc & o_wrap;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_inc) begin
      r_idx <= o_wrap ? '0 : r_idx + TILE_CNT_W'(1);
    end
  end

endmodule

// File: rtl/df_tile_ptr_gen.sv
// Tile pointer sequencer: walks x (inner), y, c, k (outer) and streams one
// {psums, ifmaps, weights} offset triplet per tile over valid/ready.
// Ports: i_clk/i_rstn clock and async active-low reset; i_start run request (IDLE only);
// i_clear synchronous abort; i_tile loop limits and steps (latched on start);
// o_busy RUN or DONE; o_done one-cycle completion pulse; o_tile_valid/i_tile_ready stream
// handshake; o_*_off offsets; o_first_c/o_last_c/o_last_tile position flags.
module df_tile_ptr_gen
  import df_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic              i_clear,
  input  TilePointers       i_tile,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_tile_valid,
  input  logic              i_tile_ready,
  output logic [ADDR_W-1:0] o_psums_off,
  output logic [ADDR_W-1:0] o_ifmaps_off,
  output logic [ADDR_W-1:0] o_weights_off,
  output logic              o_first_c,
  output logic              o_last_c,
  output logic              o_last_tile
);

  localparam int unsigned NumCh = 3;  // 0 psums, 1 ifmaps, 2 weights

  TilePtrState r_state;
  TilePointers r_tile;
  logic        r_valid, r_busy, r_done;

  logic w_load, w_hs;
  logic [TILE_CNT_W-1:0] w_x_idx, w_y_idx, w_c_idx, w_k_idx;
  logic w_x_wrap, w_y_wrap, w_c_wrap, w_k_wrap;
  logic w_x_cy, w_y_cy, w_c_cy, w_k_cy;
  logic w_last_tile;
  logic w_unused_idx;

  // Counters and accumulators restart on an accepted start or any clear.
  assign w_load      = ((r_state == TPG_IDLE) & i_start) | i_clear;
  // A handshake coinciding with i_clear is not counted.
  assign w_hs        = r_valid & i_tile_ready & ~i_clear;
  assign w_last_tile = w_x_wrap & w_y_wrap & w_c_wrap & w_k_wrap;
  assign w_unused_idx = ^{w_x_idx, w_y_idx, w_k_idx};

  df_loop_level u_lvl_x (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_clr(w_load), .i_inc(w_hs), .i_lim(r_tile.x_lim),
    .o_idx(w_x_idx), .o_wrap(w_x_wrap), .o_carry(w_x_cy)
  );
  df_loop_level u_lvl_y (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_clr(w_load), .i_inc(w_x_cy), .i_lim(r_tile.y_lim),
    .o_idx(w_y_idx), .o_wrap(w_y_wrap), .o_carry(w_y_cy)
  );
  df_loop_level u_lvl_c (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_clr(w_load), .i_inc(w_y_cy), .i_lim(r_tile.c_lim),
    .o_idx(w_c_idx), .o_wrap(w_c_wrap), .o_carry(w_c_cy)
  );
  df_loop_level u_lvl_k (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_clr(w_load), .i_inc(w_c_cy), .i_lim(r_tile.k_lim),
    .o_idx(w_k_idx), .o_wrap(w_k_wrap), .o_carry(w_k_cy)
  );

  // Sequencer FSM; w_k_cy is the handshake of the final tile.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= TPG_IDLE;
      r_tile  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_clear) begin
      r_state <= TPG_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        TPG_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_tile  <= i_tile;
            r_state <= TPG_RUN;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        TPG_RUN: begin
          if (w_k_cy) begin
            r_state <= TPG_DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        TPG_DONE: begin
          r_state <= TPG_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: r_state <= TPG_IDLE;
      endcase
    end
  end

  // Per-stream step for each loop level [ch][x,y,c,k]; unused levels contribute 0.
  logic [ADDR_W-1:0] w_step [NumCh][4];
  always_comb begin
    w_step       = '{default: '0};
    w_step[0][0] = ADDR_W'(r_tile.psums.x_step);
    w_step[0][1] = ADDR_W'(r_tile.psums.y_step);
    w_step[0][3] = ADDR_W'(r_tile.psums.k_step);
    w_step[1][0] = ADDR_W'(r_tile.ifmaps.x_step);
    w_step[1][1] = ADDR_W'(r_tile.ifmaps.y_step);
    w_step[1][2] = ADDR_W'(r_tile.ifmaps.c_step);
    w_step[2][2] = ADDR_W'(r_tile.weights.c_step);
    w_step[2][3] = ADDR_W'(r_tile.weights.k_step);
  end

  // Offset accumulators. Each base holds the offset at index 0 of every inner level, so a
  // wrap reloads from the outer base plus that level's step instead of multiplying.
  logic [ADDR_W-1:0] r_off [NumCh];
  logic [ADDR_W-1:0] r_base_y [NumCh];
  logic [ADDR_W-1:0] r_base_c [NumCh];
  logic [ADDR_W-1:0] r_base_k [NumCh];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int ch = 0; ch < NumCh; ch++) begin
        r_off[ch]    <= '0;
        r_base_y[ch] <= '0;
        r_base_c[ch] <= '0;
        r_base_k[ch] <= '0;
      end
    end else if (w_load) begin
      for (int ch = 0; ch < NumCh; ch++) begin
        r_off[ch]    <= '0;
        r_base_y[ch] <= '0;
        r_base_c[ch] <= '0;
        r_base_k[ch] <= '0;
      end
    end else if (w_hs && !w_last_tile) begin
      for (int ch = 0; ch < NumCh; ch++) begin
        if (w_c_cy) begin
          r_off[ch]    <= r_base_k[ch] + w_step[ch][3];
          r_base_k[ch] <= r_base_k[ch] + w_step[ch][3];
          r_base_c[ch] <= r_base_k[ch] + w_step[ch][3];
          r_base_y[ch] <= r_base_k[ch] + w_step[ch][3];
        end else if (w_y_cy) begin
          r_off[ch]    <= r_base_c[ch] + w_step[ch][2];
          r_base_c[ch] <= r_base_c[ch] + w_step[ch][2];
          r_base_y[ch] <= r_base_c[ch] + w_step[ch][2];
        end else if (w_x_cy) begin
          r_off[ch]    <= r_base_y[ch] + w_step[ch][1];
          r_base_y[ch] <= r_base_y[ch] + w_step[ch][1];
        end else begin
          r_off[ch] <= r_off[ch] + w_step[ch][0];
        end
      end
    end
  end

  // Offsets and flags read as zero whenever no tile is presented.
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_tile_valid  = r_valid;
  assign o_psums_off   = r_valid ? r_off[0] : '0;
  assign o_ifmaps_off  = r_valid ? r_off[1] : '0;
  assign o_weights_off = r_valid ? r_off[2] : '0;
  assign o_first_c     = r_valid & (w_c_idx == '0);
  assign o_last_c      = r_valid & w_c_wrap;
  assign o_last_tile   = r_valid & w_last_tile;

endmodule

// File: tb/tb_df_tile_ptr_gen.sv
// Self-checking bench for df_tile_ptr_gen: a transaction-level model derives every
// tile's offsets from its loop indices and is compared on each negative clock edge.
module tb_df_tile_ptr_gen;
  import df_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_start, i_clear, i_tile_ready;
  TilePointers i_tile;
  logic        o_busy, o_done, o_tile_valid;
  logic [31:0] o_psums_off, o_ifmaps_off, o_weights_off;
  logic        o_first_c, o_last_c, o_last_tile;

  always #5 clk = ~clk;

  df_tile_ptr_gen #(.ADDR_W(32)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(i_start), .i_clear(i_clear), .i_tile(i_tile),
    .o_busy(o_busy), .o_done(o_done), .o_tile_valid(o_tile_valid),
    .i_tile_ready(i_tile_ready), .o_psums_off(o_psums_off), .o_ifmaps_off(o_ifmaps_off),
    .o_weights_off(o_weights_off), .o_first_c(o_first_c), .o_last_c(o_last_c),
    .o_last_tile(o_last_tile)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected tile p from its decomposed loop indices (x innermost, k outermost).
  function automatic void exp_tile(input TilePointers t, input longint p,
                                   output logic [31:0] ps, output logic [31:0] ifm,
                                   output logic [31:0] wt, output logic [2:0] fl);
    longint nx, ny, nc, nk, x, y, c, k, q;
    nx = longint'(t.x_lim) + 1;
    ny = longint'(t.y_lim) + 1;
    nc = longint'(t.c_lim) + 1;
    nk = longint'(t.k_lim) + 1;
    x = p % nx; q = p / nx;
    y = q % ny; q = q / ny;
    c = q % nc; k = q / nc;
    ps  = 32'(x * longint'(t.psums.x_step) + y * longint'(t.psums.y_step)
              + k * longint'(t.psums.k_step));
    ifm = 32'(x * longint'(t.ifmaps.x_step) + y * longint'(t.ifmaps.y_step)
              + c * longint'(t.ifmaps.c_step));
    wt  = 32'(k * longint'(t.weights.k_step) + c * longint'(t.weights.c_step));
    fl  = {c == 0, c == longint'(t.c_lim), p == nx * ny * nc * nk - 1};
  endfunction

  // Model state and capture of accepted tiles.
  bit          m_run, m_done;
  longint      m_ptr, m_n;
  TilePointers m_cfg;
  int          done_cnt = 0;
  logic [31:0] cap_ps[$];
  logic [31:0] cap_w[$];

  always @(negedge clk) begin
    logic [31:0] eps, eif, ew;
    logic [2:0]  efl;
    if (!rstn) begin
      m_run  = 1'b0;
      m_done = 1'b0;
      chk("rst_valid", o_tile_valid, 0);
      chk("rst_busy_done", {o_busy, o_done}, 0);
      chk("rst_offsets", {o_psums_off ^ o_ifmaps_off, o_weights_off}, 0);
      chk("rst_flags", {o_first_c, o_last_c, o_last_tile}, 0);
    end else begin
      chk("valid", o_tile_valid, m_run);
      chk("done", o_done, m_done);
      chk("busy", o_busy, m_run | m_done);
      if (o_done) done_cnt++;
      if (m_run) begin
        exp_tile(m_cfg, m_ptr, eps, eif, ew, efl);
        chk("psums_off", o_psums_off, eps);
        chk("ifmaps_off", o_ifmaps_off, eif);
        chk("weights_off", o_weights_off, ew);
        chk("flags", {o_first_c, o_last_c, o_last_tile}, efl);
      end
      if (i_clear) begin
        m_run  = 1'b0;
        m_done = 1'b0;
      end else if (m_run) begin
        if (i_tile_ready) begin
          cap_ps.push_back(o_psums_off);
          cap_w.push_back(o_weights_off);
          if (m_ptr == m_n - 1) begin
            m_run  = 1'b0;
            m_done = 1'b1;
          end else begin
            m_ptr++;
          end
        end
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (i_start) begin
        m_cfg = i_tile;
        m_ptr = 0;
        m_n   = (longint'(i_tile.x_lim) + 1) * (longint'(i_tile.y_lim) + 1)
              * (longint'(i_tile.c_lim) + 1) * (longint'(i_tile.k_lim) + 1);
        m_run = 1'b1;
      end
    end
  end

  task automatic start_run(input TilePointers cfg);
    @(posedge clk); #1;
    i_tile  = cfg;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready toggles 1,0,1,0.
  // clear_at >= 0 asserts i_clear with ready once that many tiles were accepted.
  task automatic drive(input int mode, input int clear_at, input int start_at,
                       output int n_hs, output int n_done);
    int d0, c0;
    bit fin;
    d0  = done_cnt;
    c0  = cap_ps.size();
    fin = 1'b0;
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      i_tile_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      i_start      = (cyc == start_at);
      if (clear_at >= 0 && (cap_ps.size() - c0) == clear_at && o_tile_valid) begin
        i_clear      = 1'b1;
        i_tile_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (i_clear) fin = 1'b1;
      i_clear = 1'b0;
      i_start = 1'b0;
      if (done_cnt != d0) fin = 1'b1;
    end
    chk("run_finished", fin, 1);
    repeat (2) @(posedge clk);
    #1;
    i_tile_ready = 1'b1;
    n_hs   = cap_ps.size() - c0;
    n_done = done_cnt - d0;
  endtask

  TilePointers cfg1, cfg16, cfgw;
  int n, nd, c0;
  int lit_ps[9] = '{0, 4, 16, 20, 0, 4, 16, 20, 64};
  int lit_w[4]  = '{0, 100, 3, 103};

  initial begin
    rstn = 1'b0; i_start = 1'b0; i_clear = 1'b0; i_tile_ready = 1'b1; i_tile = '0;

    cfg1 = '0;
    cfg1.psums   = '{x_step: 24'd1, y_step: 24'd1, k_step: 24'd1};
    cfg1.ifmaps  = '{x_step: 24'd1, y_step: 24'd1, c_step: 24'd1};
    cfg1.weights = '{k_step: 24'd1, c_step: 24'd1};

    cfg16 = '0;
    cfg16.x_lim = 12'd1; cfg16.y_lim = 12'd1; cfg16.c_lim = 12'd1; cfg16.k_lim = 12'd1;
    cfg16.psums   = '{x_step: 24'd4, y_step: 24'd16, k_step: 24'd64};
    cfg16.ifmaps  = '{x_step: 24'd2, y_step: 24'd8, c_step: 24'd32};
    cfg16.weights = '{k_step: 24'd3, c_step: 24'd100};

    cfgw = '0;
    cfgw.x_lim = 12'hFFF; cfgw.y_lim = 12'hFFF;
    cfgw.psums   = '{x_step: 24'hFFFFFF, y_step: 24'h000FFF, k_step: 24'hFFFFFF};
    cfgw.ifmaps  = '{x_step: 24'h000FFF, y_step: 24'hFFFFFF, c_step: 24'h000FFF};
    cfgw.weights = '{k_step: 24'hFFFFFF, c_step: 24'hFFFFFF};

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Single-tile run.
    start_run(cfg1);
    drive(0, -1, -1, n, nd);
    chk("t1_tiles", n, 1);
    chk("t1_done_pulses", nd, 1);

    // 16-tile run with ready held high.
    c0 = cap_ps.size();
    start_run(cfg16);
    drive(0, -1, -1, n, nd);
    chk("t2_tiles", n, 16);
    chk("t2_done_pulses", nd, 1);
    for (int i = 0; i < 9; i++) chk("t2_psums_seq", cap_ps[c0 + i], lit_ps[i]);
    for (int i = 0; i < 16; i++) chk("t2_weights_seq", cap_w[c0 + i], lit_w[i / 4]);

    // Same config with ready toggling and a stray start mid-run.
    c0 = cap_ps.size();
    start_run(cfg16);
    drive(1, -1, 3, n, nd);
    chk("t3_tiles", n, 16);
    chk("t3_done_pulses", nd, 1);
    for (int i = 0; i < 9; i++) chk("t3_psums_seq", cap_ps[c0 + i], lit_ps[i]);
    for (int i = 0; i < 16; i++) chk("t3_weights_seq", cap_w[c0 + i], lit_w[i / 4]);

    // Clear at tile 5 together with ready, then a fresh run from tile 0.
    start_run(cfg16);
    drive(0, 5, -1, n, nd);
    chk("t4_tiles_before_clear", n, 5);
    chk("t4_no_done", nd, 0);
    c0 = cap_ps.size();
    start_run(cfg16);
    drive(0, -1, -1, n, nd);
    chk("t4_restart_tiles", n, 16);
    chk("t4_restart_first_psums", cap_ps[c0 + 1], 4);

    // Modulo-2^32 wrap with large steps; aborted by clear after 4200 tiles.
    c0 = cap_ps.size();
    start_run(cfgw);
    drive(0, 4200, -1, n, nd);
    chk("t5_tiles", n, 4200);
    chk("t5_no_done", nd, 0);
    chk("t5_psums_300", cap_ps[c0 + 300], 32'd738197204);
    chk("t5_psums_4095", cap_ps[c0 + 4095], 32'hFEFFF001);
    chk("t5_psums_4096", cap_ps[c0 + 4096], 32'h00000FFF);

    // Asynchronous reset mid-run.
    start_run(cfg16);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t6_async_valid", o_tile_valid, 0);
    chk("t6_async_busy", o_busy, 0);
    chk("t6_async_offsets", {o_psums_off, o_weights_off}, 0);
    @(posedge clk); #1 rstn = 1'b1;
    c0 = cap_ps.size();
    start_run(cfg16);
    drive(0, -1, -1, n, nd);
    chk("t6_after_reset_tiles", n, 16);
    chk("t6_after_reset_psums8", cap_ps[c0 + 8], 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
